// File: rtl/pwm_refresh_mc.sv
// pwm_refresh_mc: burst-reads packed PWM on-times from RAM into a shadow vector,
// then commits the shadow atomically to the PWM generator on-vector.
module pwm_refresh_mc #(
    parameter int P_NO_CHANNELS      = 16,
    parameter int P_PWM_RESOLUTION   = 16,
    parameter int P_CH_PER_WORD      = 2,
    parameter int P_RAM_DATA_W       = P_CH_PER_WORD * P_PWM_RESOLUTION,
    parameter int P_NO_WORDS         = P_NO_CHANNELS / P_CH_PER_WORD,
    parameter int P_RAM_ADDR_W       = (P_NO_WORDS > 1) ? $clog2(P_NO_WORDS) : 1,
    parameter int P_RAM_RD_DELAY     = 2,
    parameter int P_COMMIT_IMMEDIATE = 0,
    parameter int P_ON_VEC_W         = P_NO_CHANNELS * P_PWM_RESOLUTION
) (
    input  logic                    clk_ir,
    input  logic                    rst_il,
    output logic                    pwm_ram_rd_en_od,
    output logic [P_RAM_ADDR_W-1:0] pwm_ram_rd_addr_od,
    input  logic [P_RAM_DATA_W-1:0] pwm_ram_rd_data_id,
    input  logic                    pwm_refresh_ih,
    input  logic                    pwm_period_end_ih,
    output logic                    pwm_refresh_busy_od,
    output logic                    pwm_refresh_done_od,
    output logic [P_ON_VEC_W-1:0]   pwm_on_vec_od
);
    localparam int DC_W = (P_RAM_RD_DELAY > 1) ? $clog2(P_RAM_RD_DELAY) : 1;
    localparam logic [P_RAM_ADDR_W-1:0] LAST_WORD = P_RAM_ADDR_W'(P_NO_WORDS - 1);
    localparam logic [DC_W-1:0] LAST_DRAIN = DC_W'(P_RAM_RD_DELAY - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_COMMIT} state_t;

    state_t                                    state, state_nxt;
    logic [P_RAM_ADDR_W-1:0]                   addr;
    logic [DC_W-1:0]                           dcnt;
    logic                                      pending;
    logic                                      commit;
    logic [P_ON_VEC_W-1:0]                     shadow;
    logic [P_RAM_RD_DELAY-1:0]                 dl_v;
    logic [P_RAM_RD_DELAY-1:0][P_RAM_ADDR_W-1:0] dl_a;

    assign pwm_ram_rd_en_od    = (state == READ);
    assign pwm_ram_rd_addr_od  = addr;
    assign pwm_refresh_busy_od = (state != IDLE);

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE:        state_nxt = pwm_refresh_ih ? READ : IDLE;
            READ:        state_nxt = (addr == LAST_WORD) ? DRAIN : READ;
            DRAIN:       state_nxt = (dcnt == LAST_DRAIN) ? WAIT_COMMIT : DRAIN;
            WAIT_COMMIT: begin
                commit    = pwm_period_end_ih || (P_COMMIT_IMMEDIATE != 0);
                state_nxt = !commit ? WAIT_COMMIT : (pending || pwm_refresh_ih) ? READ : IDLE;
            end
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state               <= IDLE;
            addr                <= '0;
            dcnt                <= '0;
            pending             <= 1'b0;
            shadow              <= '0;
            dl_v                <= '0;
            dl_a                <= '0;
            pwm_refresh_done_od <= 1'b0;
            pwm_on_vec_od       <= '0;
        end else begin
            state               <= state_nxt;
            addr                <= (state == READ && addr != LAST_WORD) ? addr + 1'b1 : '0;
            dcnt                <= (state == DRAIN && dcnt != LAST_DRAIN) ? dcnt + 1'b1 : '0;
            // a request arriving in the commit cycle is consumed by the restart itself
            pending             <= commit ? 1'b0 : (pending || (pwm_refresh_ih && state != IDLE));
            pwm_refresh_done_od <= commit;
            if (commit)
                pwm_on_vec_od <= shadow;
            dl_v[0] <= pwm_ram_rd_en_od;
            dl_a[0] <= addr;
            for (int i = 1; i < P_RAM_RD_DELAY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
            end
            if (dl_v[P_RAM_RD_DELAY-1])
                for (int j = 0; j < P_CH_PER_WORD; j++)
                    shadow[(int'(dl_a[P_RAM_RD_DELAY-1]) * P_CH_PER_WORD + j) * P_PWM_RESOLUTION +: P_PWM_RESOLUTION]
                        <= pwm_ram_rd_data_id[j*P_PWM_RESOLUTION +: P_PWM_RESOLUTION];
        end
    end
endmodule

// File: tb/tb_pwm_refresh_mc.sv
// tb_pwm_refresh_mc: directed/randomized bench for pwm_refresh_mc with a cycle-timed reference.
module tb_pwm_refresh_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rd_a, busy_a, done_a, ref_a = 1'b0, pe_a = 1'b0;
    logic [2:0]  addr_a;
    logic [31:0] pa1, pa2;
    logic [255:0] vec_a;
    logic [31:0] mem_a [8];

    logic        rd_b, busy_b, done_b, ref_b = 1'b0, pe_b = 1'b0;
    logic [2:0]  addr_b;
    logic [31:0] pb1, pb2;
    logic [255:0] vec_b;
    logic [31:0] mem_b [8];

    logic        rd_c, busy_c, done_c, ref_c = 1'b0, pe_c = 1'b0;
    logic [2:0]  addr_c;
    logic [15:0] pc1;
    logic [79:0] vec_c;
    logic [15:0] mem_c [5];

    pwm_refresh_mc #(.P_COMMIT_IMMEDIATE(1)) u_a (
        .clk_ir(clk), .rst_il(rst_n), .pwm_ram_rd_en_od(rd_a), .pwm_ram_rd_addr_od(addr_a),
        .pwm_ram_rd_data_id(pa2), .pwm_refresh_ih(ref_a), .pwm_period_end_ih(pe_a),
        .pwm_refresh_busy_od(busy_a), .pwm_refresh_done_od(done_a), .pwm_on_vec_od(vec_a));

    pwm_refresh_mc #(.P_COMMIT_IMMEDIATE(0)) u_b (
        .clk_ir(clk), .rst_il(rst_n), .pwm_ram_rd_en_od(rd_b), .pwm_ram_rd_addr_od(addr_b),
        .pwm_ram_rd_data_id(pb2), .pwm_refresh_ih(ref_b), .pwm_period_end_ih(pe_b),
        .pwm_refresh_busy_od(busy_b), .pwm_refresh_done_od(done_b), .pwm_on_vec_od(vec_b));

    pwm_refresh_mc #(.P_NO_CHANNELS(5), .P_CH_PER_WORD(1), .P_RAM_RD_DELAY(1), .P_COMMIT_IMMEDIATE(1)) u_c (
        .clk_ir(clk), .rst_il(rst_n), .pwm_ram_rd_en_od(rd_c), .pwm_ram_rd_addr_od(addr_c),
        .pwm_ram_rd_data_id(pc1), .pwm_refresh_ih(ref_c), .pwm_period_end_ih(pe_c),
        .pwm_refresh_busy_od(busy_c), .pwm_refresh_done_od(done_c), .pwm_on_vec_od(vec_c));

    // RAM fixtures: data appears RD_DELAY cycles after the strobe, garbage otherwise
    always @(posedge clk) begin
        pa1 <= rd_a ? mem_a[addr_a] : $urandom;
        pa2 <= pa1;
        pb1 <= rd_b ? mem_b[addr_b] : $urandom;
        pb2 <= pb1;
        pc1 <= rd_c ? mem_c[addr_c] : 16'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string p, input int c, input logic o_rd, input logic [2:0] o_ad,
                           input logic o_bz, input logic o_dn, input logic [255:0] o_v,
                           input logic e_rd, input int e_ad, input logic e_bz, input logic e_dn,
                           input logic [255:0] e_v);
        chk($sformatf("%s.rd_en@%0d", p, c), 256'(o_rd), 256'(e_rd));
        chk($sformatf("%s.addr@%0d", p, c), 256'(o_ad), 256'(e_ad));
        chk($sformatf("%s.busy@%0d", p, c), 256'(o_bz), 256'(e_bz));
        chk($sformatf("%s.done@%0d", p, c), 256'(o_dn), 256'(e_dn));
        chk($sformatf("%s.on_vec@%0d", p, c), o_v, e_v);
    endtask

    function automatic logic [255:0] exp_a();
        logic [255:0] v = '0;
        for (int ch = 0; ch < 16; ch++) v[ch*16 +: 16] = mem_a[ch/2][(ch%2)*16 +: 16];
        return v;
    endfunction

    function automatic logic [255:0] exp_b();
        logic [255:0] v = '0;
        for (int ch = 0; ch < 16; ch++) v[ch*16 +: 16] = mem_b[ch/2][(ch%2)*16 +: 16];
        return v;
    endfunction

    function automatic logic [255:0] exp_c();
        logic [255:0] v = '0;
        for (int ch = 0; ch < 5; ch++) v[ch*16 +: 16] = mem_c[ch];
        return v;
    endfunction

    // single refresh at cycle 0, immediate commit: rd_en 1..8, done 12
    task automatic run_a_basic(input logic [255:0] prev, input logic [255:0] e);
        for (int c = 0; c <= 14; c++) begin
            logic rd;
            ref_a = (c == 0);
            rd = (c >= 1 && c <= 8);
            chk_cyc("a", c, rd_a, addr_a, busy_a, done_a, vec_a,
                    rd, rd ? c - 1 : 0, c >= 1 && c < 12, c == 12, c >= 12 ? e : prev);
            tick();
        end
    endtask

    initial begin
        logic [255:0] e1, e2, cur;
        tick();
        tick();
        chk_cyc("rst_a", 0, rd_a, addr_a, busy_a, done_a, vec_a, 0, 0, 0, 0, '0);
        chk_cyc("rst_b", 0, rd_b, addr_b, busy_b, done_b, vec_b, 0, 0, 0, 0, '0);
        chk_cyc("rst_c", 0, rd_c, addr_c, busy_c, done_c, 256'(vec_c), 0, 0, 0, 0, '0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int w = 0; w < 8; w++) mem_a[w] = {16'(2*w+1), 16'(2*w)};
        e1 = exp_a();
        run_a_basic('0, e1);
        for (int ch = 0; ch < 16; ch++)
            chk($sformatf("a.ch%0d", ch), 256'(vec_a[ch*16 +: 16]), 256'(ch));
        cur = e1;

        for (int w = 0; w < 8; w++) mem_a[w] = $urandom;
        e1 = exp_a();
        e2 = '0;
        for (int c = 0; c <= 26; c++) begin
            logic rd;
            ref_a = (c <= 3) || (c == 11);
            rd = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
            chk_cyc("a2", c, rd_a, addr_a, busy_a, done_a, vec_a,
                    rd, !rd ? 0 : (c <= 8 ? c - 1 : c - 12), c >= 1 && c <= 22,
                    c == 12 || c == 23, c >= 23 ? e2 : (c >= 12 ? e1 : cur));
            if (c == 9) begin
                for (int w = 0; w < 8; w++) mem_a[w] = $urandom;
                e2 = exp_a();
            end
            tick();
        end

        for (int w = 0; w < 8; w++) mem_a[w] = $urandom;
        for (int c = 0; c < 4; c++) begin
            ref_a = (c == 0);
            tick();
        end
        chk("a3.rd_en_pre", 256'(rd_a), 256'(1));
        chk("a3.addr_pre", 256'(addr_a), 256'(3));
        rst_n = 1'b0;
        #1;
        chk_cyc("a3.rst", 4, rd_a, addr_a, busy_a, done_a, vec_a, 0, 0, 0, 0, '0);
        tick();
        rst_n = 1'b1;
        for (int c = 5; c <= 9; c++) begin
            chk_cyc("a3.idle", c, rd_a, addr_a, busy_a, done_a, vec_a, 0, 0, 0, 0, '0);
            tick();
        end
        for (int w = 0; w < 8; w++) mem_a[w] = $urandom;
        run_a_basic('0, exp_a());

        for (int w = 0; w < 8; w++) mem_b[w] = $urandom;
        e1 = exp_b();
        for (int c = 0; c <= 24; c++) begin
            logic rd;
            ref_b = (c == 0);
            pe_b = (c == 5) || (c == 20);
            rd = (c >= 1 && c <= 8);
            chk_cyc("b", c, rd_b, addr_b, busy_b, done_b, vec_b,
                    rd, rd ? c - 1 : 0, c >= 1 && c <= 20, c == 21, c >= 21 ? e1 : '0);
            tick();
        end
        pe_b = 1'b0;

        for (int w = 0; w < 5; w++) mem_c[w] = 16'($urandom);
        e1 = exp_c();
        for (int c = 0; c <= 10; c++) begin
            logic rd;
            ref_c = (c == 0);
            rd = (c >= 1 && c <= 5);
            chk_cyc("c", c, rd_c, addr_c, busy_c, done_c, 256'(vec_c),
                    rd, rd ? c - 1 : 0, c >= 1 && c < 8, c == 8, c >= 8 ? e1 : '0);
            tick();
        end
        for (int ch = 0; ch < 5; ch++)
            chk($sformatf("c.ch%0d", ch), 256'(vec_c[ch*16 +: 16]), 256'(mem_c[ch]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_refresh_mc.md
# pwm_refresh_mc

Multi-channel, double-buffered successor to the PWM refresh path in the visual cortex. On a refresh request it burst-reads the PWM RAM, where each word packs several channels' on-times, into a shadow vector. The shadow is then committed atomically to the PWM generator's on-vector, either at the next PWM period boundary or immediately, depending on a mode parameter. It sits between the PWM RAM read port and the PWM generator bank, and reports busy/done status to the controller.

## Interface
- P_NO_CHANNELS, 16: number of PWM channels; must be a multiple of P_CH_PER_WORD.
- P_PWM_RESOLUTION, 16: bits per channel on-time.
- P_CH_PER_WORD, 2: channels packed per RAM word (1, 2 or 4).
- P_RAM_DATA_W, P_CH_PER_WORD*P_PWM_RESOLUTION: RAM read data width.
- P_NO_WORDS, P_NO_CHANNELS/P_CH_PER_WORD: RAM words per refresh.
- P_RAM_ADDR_W, $clog2(P_NO_WORDS) (minimum 1): RAM address width.
- P_RAM_RD_DELAY, 2: RAM read latency in cycles; must be ≥1.
- P_COMMIT_IMMEDIATE, 0: 1 = commit as soon as the read completes; 0 = wait for pwm_period_end_ih.
- P_ON_VEC_W, P_NO_CHANNELS*P_PWM_RESOLUTION: on-vector width.

Ports:
- clk_ir, input, 1: clock.
- rst_il, input, 1: reset, asynchronous, active-low.
- pwm_ram_rd_en_od, output, 1: read strobe to PWM RAM.
- pwm_ram_rd_addr_od, output, P_RAM_ADDR_W: read word address.
- pwm_ram_rd_data_id, input, P_RAM_DATA_W: read data, valid P_RAM_RD_DELAY cycles after the strobe.
- pwm_refresh_ih, input, 1: refresh request (level-sampled each cycle).
- pwm_period_end_ih, input, 1: one-cycle pulse at the PWM period boundary.
- pwm_refresh_busy_od, output, 1: high while state ≠ IDLE.
- pwm_refresh_done_od, output, 1: one-cycle pulse, registered, coincident with the on-vector update.
- pwm_on_vec_od, output, P_ON_VEC_W: active on-times; channel c is at [c*P_PWM_RESOLUTION +: P_PWM_RESOLUTION].

## Operation
- FSM states: IDLE, READ, DRAIN, WAIT_COMMIT.
- IDLE: on pwm_refresh_ih, go to READ; the word address counter clears to 0.
- READ: rd_en=1, addr = 0..P_NO_WORDS-1 (one word per cycle). After the strobe with addr=P_NO_WORDS-1, go to DRAIN.
- DRAIN: rd_en=0, addr held at 0. Lasts exactly P_RAM_RD_DELAY cycles, then go to WAIT_COMMIT.
- Capture: a P_RAM_RD_DELAY-deep delay line carries the strobe and its word index. On delayed-strobe, slot j of the data (bits [j*P_PWM_RESOLUTION +: P_PWM_RESOLUTION]) is written into shadow channel word*P_CH_PER_WORD+j.
- The shadow register is separate from pwm_on_vec_od. pwm_on_vec_od changes only on commit.
- WAIT_COMMIT: commit fires when (pwm_period_end_ih==1 or P_COMMIT_IMMEDIATE==1). On commit:
  - pwm_on_vec_od <= shadow, and done pulses.
  - Next state is READ if a refresh is pending (pending flag cleared), else IDLE.
- Pending refresh: pwm_refresh_ih high while busy (including the commit cycle) sets a single pending flag. Further requests merge into it.
- pwm_period_end_ih outside WAIT_COMMIT is ignored and not remembered.
- Reset, asynchronous at any point, including mid-READ/DRAIN:
  - All outputs go to 0, and shadow, pending, delay line and FSM clear; state goes to IDLE.
  - Any in-flight RAM data returning after reset is discarded.

## Timing
- Refresh sampled in IDLE at cycle 0:
  - rd_en high during cycles 1..P_NO_WORDS.
  - Last capture at the end of cycle P_NO_WORDS+P_RAM_RD_DELAY.
  - WAIT_COMMIT at cycle P_NO_WORDS+P_RAM_RD_DELAY+1.
- Immediate mode: on-vector and done update at cycle P_NO_WORDS+P_RAM_RD_DELAY+2. With defaults (8 words, delay 2), done is high in cycle 12.
- Deferred mode: update occurs the cycle after the first period_end sampled in WAIT_COMMIT.
- busy rises in cycle 1 and falls in the cycle done is high, unless a pending refresh exists; in that case busy stays high and READ restarts in that cycle.
- Address width: the counter does not wrap past P_NO_WORDS-1. A non-power-of-2 P_NO_WORDS must still stop at P_NO_WORDS-1.

## Test plan
- Defaults, immediate mode, RAM word w = {16'(2w+1), 16'(2w)}:
  - Pulse refresh at cycle 0.
  - Expect rd_en during cycles 1-8 with addr 0-7, and done in cycle 12.
  - Expect channel c on-time = c.
- Deferred mode, period_end at cycles 5 and 20:
  - Expect no on-vector change at cycle 5; update and done at cycle 21.
  - Expect busy high during cycles 1-20.
- Refresh held high during cycles 0-3, plus another pulse in the commit cycle:
  - Expect exactly two passes; the second READ starts in the cycle done is high, and busy never drops between passes.
- Reset asserted at cycle 4 of READ:
  - Expect all outputs at 0 immediately.
  - After release, a new refresh produces correct data with no stale captures.
- P_CH_PER_WORD=1, P_RAM_RD_DELAY=1, P_NO_CHANNELS=5, immediate mode:
  - Expect addr 0-4 with no wrap, and done at cycle 8.
  - Expect packing verified per channel.
